// File: rtl/cnn_pkg.sv
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared state encoding and network-size constants for the
//                CONV_POOL_CONV engine and its OFM collector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } collector_state_e;

    localparam int CO_1     = 256;
    localparam int OFM_SIDE = 13;

endpackage

`default_nettype wire

// File: rtl/ofm_ram.sv
// ============================================================================
//  Module      : ofm_ram
//  Description : Single-port synchronous RAM, one-cycle registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 43264,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk1,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk1) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/ofm_collector.sv
// ============================================================================
//  Module      : ofm_collector
//  Description : Captures the pooled OFM stream into a buffer and replays it
//                with channel/row/column tags over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_collector
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CO         = CO_1,
    parameter int OFM        = OFM_SIDE,
    parameter int DEPTH      = CO * OFM * OFM,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  end_op,
    input  logic                  clear,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [7:0]            rd_chan,
    output logic [3:0]            rd_row,
    output logic [3:0]            rd_col,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
    localparam logic [7:0]    c_chan_max = 8'(CO - 1);
    localparam logic [3:0]    c_side_max = 4'(OFM - 1);

    collector_state_e      r_state;
    logic [CW-1:0]         r_wr_cnt;
    logic [CW-1:0]         r_rd_addr;
    logic [7:0]            r_rd_chan;
    logic [3:0]            r_rd_row;
    logic [3:0]            r_rd_col;

    logic                  r_inflight;
    logic [7:0]            r_pend_chan;
    logic [3:0]            r_pend_row;
    logic [3:0]            r_pend_col;
    logic                  r_pend_last;

    logic                  r_sk_valid;
    logic [DATA_WIDTH-1:0] r_sk_data;
    logic [7:0]            r_sk_chan;
    logic [3:0]            r_sk_row;
    logic [3:0]            r_sk_col;
    logic                  r_sk_last;

    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_we;
    logic                  w_issue;
    logic                  w_issue_last;
    logic [1:0]            w_occ;

    assign w_pop        = rd_valid && rd_ready;
    assign w_full       = (r_wr_cnt == c_depth);
    assign w_we         = (r_state == ST_COLLECT) && in_valid && !w_full && !clear;
    assign w_issue_last = (r_rd_addr == r_wr_cnt - c_cnt_one);
    assign w_ram_addr   = (r_state == ST_DRAIN) ? r_rd_addr[ADDR_WIDTH-1:0]
                                                : r_wr_cnt[ADDR_WIDTH-1:0];

    // Slots already claimed once this cycle's pop is retired: head, skid, RAM output.
    assign w_occ   = {1'b0, rd_valid} + {1'b0, r_sk_valid} + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue = (r_state == ST_DRAIN) && (r_rd_addr < r_wr_cnt) && (w_occ <= 2'd1);

    ofm_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk1  (clk1),
        .we    (w_we),
        .addr  (w_ram_addr),
        .wdata (in_data),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_COLLECT;
            r_wr_cnt    <= '0;
            r_rd_addr   <= '0;
            r_rd_chan   <= '0;
            r_rd_row    <= '0;
            r_rd_col    <= '0;
            r_inflight  <= 1'b0;
            r_pend_chan <= '0;
            r_pend_row  <= '0;
            r_pend_col  <= '0;
            r_pend_last <= 1'b0;
            r_sk_valid  <= 1'b0;
            r_sk_data   <= '0;
            r_sk_chan   <= '0;
            r_sk_row    <= '0;
            r_sk_col    <= '0;
            r_sk_last   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            rd_chan     <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
            rd_last     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            r_state    <= ST_COLLECT;
            r_wr_cnt   <= '0;
            r_rd_addr  <= '0;
            r_rd_chan  <= '0;
            r_rd_row   <= '0;
            r_rd_col   <= '0;
            r_inflight <= 1'b0;
            r_sk_valid <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (in_valid && ((r_state != ST_COLLECT) || w_full)) begin
                overflow <= 1'b1;
            end
            if (w_we) begin
                r_wr_cnt <= r_wr_cnt + c_cnt_one;
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_pend_chan <= r_rd_chan;
                r_pend_row  <= r_rd_row;
                r_pend_col  <= r_rd_col;
                r_pend_last <= w_issue_last;
                r_rd_addr   <= r_rd_addr + c_cnt_one;
                if (r_rd_col == c_side_max) begin
                    r_rd_col <= '0;
                    if (r_rd_row == c_side_max) begin
                        r_rd_row  <= '0;
                        r_rd_chan <= (r_rd_chan == c_chan_max) ? 8'd0 : r_rd_chan + 8'd1;
                    end else begin
                        r_rd_row <= r_rd_row + 4'd1;
                    end
                end else begin
                    r_rd_col <= r_rd_col + 4'd1;
                end
            end

            // Head register is the output; the skid slot only fills while the head stalls.
            if (!rd_valid || w_pop) begin
                if (r_sk_valid) begin
                    rd_data    <= r_sk_data;
                    rd_chan    <= r_sk_chan;
                    rd_row     <= r_sk_row;
                    rd_col     <= r_sk_col;
                    rd_last    <= r_sk_last;
                    r_sk_valid <= r_inflight;
                    if (r_inflight) begin
                        r_sk_data <= w_ram_rdata;
                        r_sk_chan <= r_pend_chan;
                        r_sk_row  <= r_pend_row;
                        r_sk_col  <= r_pend_col;
                        r_sk_last <= r_pend_last;
                    end
                end else begin
                    rd_valid <= r_inflight;
                    rd_last  <= r_inflight && r_pend_last;
                    if (r_inflight) begin
                        rd_data <= w_ram_rdata;
                        rd_chan <= r_pend_chan;
                        rd_row  <= r_pend_row;
                        rd_col  <= r_pend_col;
                    end
                end
            end else if (r_inflight) begin
                r_sk_valid <= 1'b1;
                r_sk_data  <= w_ram_rdata;
                r_sk_chan  <= r_pend_chan;
                r_sk_row   <= r_pend_row;
                r_sk_col   <= r_pend_col;
                r_sk_last  <= r_pend_last;
            end

            case (r_state)
                ST_COLLECT: begin
                    if (end_op) begin
                        if ((r_wr_cnt == '0) && !w_we) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            busy    <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && rd_last) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ofm_collector.sv
// ============================================================================
//  Module      : tb_ofm_collector
//  Description : Directed self-checking bench for ofm_collector on a reduced
//                4-channel 3x3 map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ofm_collector;

    localparam int DW    = 32;
    localparam int CO    = 4;
    localparam int OFM   = 3;
    localparam int DEPTH = CO * OFM * OFM;
    localparam int AW    = 6;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          end_op;
    logic          clear;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [7:0]    rd_chan;
    logic [3:0]    rd_row;
    logic [3:0]    rd_col;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cyc;

    ofm_collector #(
        .DATA_WIDTH (DW),
        .CO         (CO),
        .OFM        (OFM),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .end_op   (end_op),
        .clear    (clear),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_chan  (rd_chan),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_last  (rd_last),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_frame(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk1);
            in_valid = 1'b1;
            in_data  = DW'(base + i);
        end
        @(negedge clk1);
        in_valid = 1'b0;
    endtask

    task automatic end_pulse(input bit with_data, input int d);
        @(negedge clk1);
        end_op   = 1'b1;
        in_valid = with_data;
        in_data  = DW'(d);
        @(negedge clk1);
        end_op   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk1);
        clear = 1'b1;
        @(negedge clk1);
        clear = 1'b0;
    endtask

    // Drains n beats, comparing each against base+index and index-derived coordinates.
    task automatic drain(input int n, input int base, input bit bp, output int cycles);
        int          idx;
        bit          stall;
        logic [63:0] held;
        logic [63:0] snap;
        idx    = 0;
        stall  = 1'b0;
        held   = '0;
        cycles = 0;
        while (idx < n && cycles < 20 * n + 50) begin
            @(negedge clk1);
            cycles++;
            in_valid = 1'b0;
            snap = {13'd0, rd_valid, rd_last, rd_chan, rd_row, rd_col, rd_data};
            if (stall) chk("hold", snap, held);
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_valid && rd_ready) begin
                chk("beat", {15'd0, rd_data, rd_chan, rd_row, rd_col, rd_last},
                    {15'd0, DW'(base + idx), 8'(idx / (OFM * OFM)), 4'((idx / OFM) % OFM),
                     4'(idx % OFM), (idx == n - 1)});
                idx++;
                stall = 1'b0;
            end else begin
                stall = rd_valid;
                held  = snap;
            end
        end
        chk("drain_count", 64'(idx), 64'(n));
        @(negedge clk1);
        rd_ready = 1'b0;
        chk("done_after", {61'd0, done, busy, rd_valid}, 64'b100);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        end_op   = 1'b0;
        clear    = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(negedge clk1);
        chk("reset_flags", {59'd0, rd_valid, rd_last, busy, done, overflow}, 64'd0);
        chk("reset_data", {48'd0, rd_chan, rd_row, rd_col}, 64'd0);
        chk("reset_rdata", 64'(rd_data), 64'd0);
        rst_n = 1'b1;

        // Full frame, ready held high: latency, ordering, no bubbles.
        write_frame(DEPTH, 1000);
        end_pulse(1'b0, 0);
        chk("latency_busy", {61'd0, busy, rd_valid, done}, 64'b100);
        drain(DEPTH, 1000, 1'b0, cyc);
        chk("throughput", 64'(cyc), 64'(DEPTH + 1));
        chk("full_ovf", 64'(overflow), 64'd0);
        pulse_clear();
        chk("clear_flags", {62'd0, busy, done}, 64'd0);

        // Backpressure with random ready.
        write_frame(DEPTH, 32'h5000);
        end_pulse(1'b0, 0);
        drain(DEPTH, 32'h5000, 1'b1, cyc);
        pulse_clear();

        // Short frame.
        write_frame(5, 200);
        end_pulse(1'b0, 0);
        drain(5, 200, 1'b1, cyc);
        pulse_clear();

        // Empty frame: DONE directly, no beats.
        end_pulse(1'b0, 0);
        chk("empty_done", {61'd0, done, busy, rd_valid}, 64'b100);
        @(negedge clk1);
        rd_ready = 1'b1;
        @(negedge clk1);
        chk("empty_nobeat", 64'(rd_valid), 64'd0);
        rd_ready = 1'b0;
        pulse_clear();

        // Overflow: full buffer plus one, then a write during drain.
        write_frame(DEPTH, 700);
        chk("ovf_at_full", 64'(overflow), 64'd0);
        write_frame(1, 32'hDEAD);
        chk("ovf_set", 64'(overflow), 64'd1);
        @(negedge clk1);
        end_op = 1'b1;
        @(negedge clk1);
        end_op   = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hBEEF;
        drain(DEPTH, 700, 1'b0, cyc);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        pulse_clear();
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // in_valid together with end_op: that element is the final beat.
        write_frame(2, 900);
        end_pulse(1'b1, 902);
        drain(3, 900, 1'b0, cyc);
        pulse_clear();

        // clear together with end_op: back to COLLECT with nothing stored.
        write_frame(4, 50);
        @(negedge clk1);
        clear  = 1'b1;
        end_op = 1'b1;
        @(negedge clk1);
        clear  = 1'b0;
        end_op = 1'b0;
        chk("clr_end_state", {62'd0, busy, done}, 64'd0);
        end_pulse(1'b0, 0);
        chk("clr_end_empty", {61'd0, done, busy, rd_valid}, 64'b100);
        pulse_clear();

        // Asynchronous reset in the middle of a drain.
        write_frame(DEPTH, 400);
        end_pulse(1'b0, 0);
        rd_ready = 1'b1;
        repeat (12) @(negedge clk1);
        chk("mid_drain_valid", 64'(rd_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {59'd0, rd_valid, rd_last, busy, done, overflow}, 64'd0);
        chk("arst_data", {16'd0, rd_data, rd_chan, rd_row, rd_col}, 64'd0);
        @(negedge clk1);
        rd_ready = 1'b0;
        rst_n    = 1'b1;
        write_frame(10, 300);
        end_pulse(1'b0, 0);
        drain(10, 300, 1'b0, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ofm_collector.md
# ofm_collector

Downstream sink for the CONV_POOL_CONV engine. It captures the final pooled output stream (`pool_out_valid_1` / `data_output`) into an on-chip buffer in channel-major, row, column order. When `end_op` arrives, it replays the captured feature map over a valid/ready read port, tagged with channel/row/column coordinates. This moves result capture into RTL so synthesis and system-level benches can consume the OFM without a behavioural collector.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of one OFM element (signed, passed through untouched)
- `CO`, 256, output channels (CO_1 of the engine)
- `OFM`, 13, output feature-map side (227→55→27→27→13 for the default network)
- `DEPTH`, CO*OFM*OFM (43264), buffer entries
- `ADDR_WIDTH`, 16, ceil(log2(DEPTH))

Ports:
- `clk1`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  from `pool_out_valid_1`; one element per high cycle
- `in_data`  in  DATA_WIDTH  from `data_output`
- `end_op`  in  1  engine completion pulse
- `clear`  in  1  synchronous return to COLLECT, empties the buffer
- `rd_valid`  out  1  read beat available
- `rd_ready`  in  1  consumer accepts beat
- `rd_data`  out  DATA_WIDTH  element
- `rd_chan`  out  8  channel index of beat
- `rd_row`  out  4  row index
- `rd_col`  out  4  column index
- `rd_last`  out  1  final beat of drain
- `busy`  out  1  high in DRAIN
- `done`  out  1  high in DONE
- `overflow`  out  1  sticky: an input element was dropped

## Operation
- States:
  - COLLECT (reset state)
  - DRAIN
  - DONE
- COLLECT:
  - Each `in_valid` cycle writes `in_data` at `wr_cnt` and increments `wr_cnt`.
  - Column/row/channel write counters wrap OFM→0 at col, then row, then channel.
- `end_op` in COLLECT moves to DRAIN.
  - If `in_valid` is high in the same cycle, that element is written first and is included in the drain.
- DRAIN:
  - Reads addresses 0..`wr_cnt`-1 in order.
  - Coordinates are regenerated by separate read counters with the same wrap rule.
  - `rd_last` is high with the beat at address `wr_cnt`-1.
  - The state moves to DONE on the cycle `rd_last` is accepted.
- `end_op` with `wr_cnt`=0 goes straight to DONE with no beats.
- DONE holds until `clear`; `clear` resets `wr_cnt`, the read counters and `overflow`, and enters COLLECT.
  - `clear` in any state has the same effect and takes priority over `end_op` and `in_valid` in that cycle.
- `overflow` is set by:
  - `in_valid` while `wr_cnt`=DEPTH (element dropped)
  - `in_valid` in DRAIN or DONE (element dropped)
- `end_op` outside COLLECT is ignored.
- No arithmetic is performed on data; values are stored bit-exact.

## Timing
- Reset values:
  - state COLLECT
  - all counters 0
  - `rd_valid`, `rd_last`, `busy`, `done`, `overflow` 0
  - `rd_data`, `rd_chan`, `rd_row`, `rd_col` 0
- Buffer is a single-port synchronous RAM with 1-cycle read latency.
  - Writes occur only in COLLECT and reads only in DRAIN, so there is no port conflict.
- Latency: `end_op` sampled at edge N → `busy` high after N → first `rd_valid` high after edge N+2.
- Handshake:
  - A beat transfers on a rising edge with `rd_valid` && `rd_ready`.
  - While `rd_valid` is high and `rd_ready` is low, `rd_data`/coordinates/`rd_last` hold stable.
  - `rd_valid` never drops without a transfer.
- Throughput: with `rd_ready` held high, one beat per cycle, no bubbles after the first.
  - A 2-entry skid buffer absorbs the RAM latency when `rd_ready` deasserts.
- `done` rises the cycle after the `rd_last` transfer; `busy` falls in the same cycle.
- Reset mid-DRAIN aborts immediately; outputs return to reset values asynchronously.

## Structure
- Shared package `cnn_pkg`:
  - state enum (COLLECT/DRAIN/DONE)
  - network-size constants (CO_1=256, OFM=13) so that bench and engine agree
- One sub-module: `ofm_ram`
  - single-port sync RAM, DEPTH×DATA_WIDTH
  - ports `we`, `addr`, `wdata`, `rdata`, `clk1`; no reset on array
- The top level contains the FSM, write counters, read counters, and the skid buffer.

## Test plan
- Full frame:
  - Stimulus: 43264 `in_valid` beats with data = index; `end_op`; `rd_ready`=1.
  - Required: 43264 beats, data=index, first beat chan0/row0/col0, beat 169 at chan1/row0/col0, `rd_last` on chan255/row12/col12, `done`=1, `overflow`=0.
- Backpressure:
  - Stimulus: drain with `rd_ready` toggled by a pseudo-random pattern.
  - Required: no lost or duplicated beats; outputs stable while stalled; order preserved.
- Short frame and empty:
  - Stimulus A: 5 beats then `end_op`. Required: exactly 5 beats, `rd_last` on col4.
  - Stimulus B: `end_op` with nothing written. Required: `done` after 1 cycle with zero beats.
- Overflow:
  - Stimulus: 43265 beats, then a further `in_valid` during DRAIN.
  - Required: `overflow`=1 sticky; drain still returns exactly 43264 correct beats.
- Simultaneous events:
  - Stimulus A: `in_valid` + `end_op` in the same cycle. Required: that element is the final beat.
  - Stimulus B: `clear` + `end_op` in the same cycle. Required: COLLECT, `wr_cnt`=0.
- Reset mid-drain:
  - Stimulus: assert `rst_n`=0 after 100 beats; release; new 10-beat frame.
  - Required: all outputs at reset values; new drain returns exactly 10 beats starting at chan0/row0/col0.
